mac_learn_table: RTL
====================

# mac_learn_table

Parametrised MAC source-address learning table for the switch: N ingress ports raise learn requests carrying a hashed SA slot index; a round-robin arbiter grants one per cycle and records the port in that slot. A background sweep ages entries once per second-tick and expires stale stations. The forwarding path reads the table through a registered lookup port.

## Interface
- pPORTS, 4: number of ingress ports (≥2)
- pSLOTS, 64: table depth, power of two; slot index width AW = $clog2(pSLOTS)
- pAGE_MAX, 300: age reload value in ticks (≥1); age width GW = $clog2(pAGE_MAX+1)
- pTICK_DIV, 32768: clock cycles per aging tick; must be ≥ 2*pSLOTS
- (derived) PW = $clog2(pPORTS), port field width

- iclk  in  1  clock
- irst  in  1  reset, synchronous, active-high
- i_learn_req  in  pPORTS  per-port learn request, level, held until ack
- i_learn_slot  in  pPORTS*AW  per-port slot index, port p at [p*AW +: AW], stable while request high
- o_learn_ack  out  pPORTS  one-cycle grant pulse to served port
- i_lookup_en  in  1  lookup strobe
- i_lookup_slot  in  AW  slot to read
- o_lookup_valid  out  1  lookup result strobe
- o_lookup_hit  out  1  slot held a valid entry
- o_lookup_port  out  PW  learned port, 0 on miss
- o_sweep_active  out  1  aging sweep in progress
- o_entry_count  out  $clog2(pSLOTS+1)  number of valid entries

## Operation
- Per slot: valid bit, PW-bit port, GW-bit age.
- Arbiter: pointer r_working_port, reset 0. Each cycle scan ports from pointer upward (mod pPORTS); first requesting port is granted. Grant writes slot: valid=1, port=granted index, age=pAGE_MAX. Pointer becomes (granted+1) mod pPORTS; holds when no request. At most one grant per cycle.
- Station move: grant to a valid slot overwrites port and reloads age; entry count unchanged.
- Prescaler: counts 0..pTICK_DIV-1, wraps; tick when count == pTICK_DIV-1.
- Sweep: starts cycle after tick, visits slots 0..pSLOTS-1, one per cycle. Valid entry with age>1: age−1. Valid entry with age==1: valid=0, age=0 (expiry). Invalid slots untouched.
- Collision: learn write and sweep on same slot in same cycle → learn wins (valid=1, age=pAGE_MAX, no expiry, no decrement).
- Entry count: +1 on grant to invalid slot, −1 on expiry; both in one cycle → unchanged. Never exceeds pSLOTS.
- Lookup reads table state as it was before that cycle's updates (read-before-write).

## Timing
- Reset values: all valid=0, ages=0, ports=0, pointer=0, prescaler=0, sweep idle; o_learn_ack=0, o_lookup_valid=0, o_lookup_hit=0, o_lookup_port=0, o_sweep_active=0, o_entry_count=0.
- Learn: request sampled cycle N, table written at edge ending N, o_learn_ack high cycle N+1. Requester drops request on ack; request still high in N+1 is treated as a new request.
- Lookup: i_lookup_en at cycle N → o_lookup_valid/hit/port in cycle N+1, one cycle wide; back-to-back lookups every cycle allowed.
- o_sweep_active high exactly pSLOTS cycles, from cycle after tick.
- Reset mid-sweep aborts the sweep; reset mid-request drops grant, no ack issued.

## Configuration
- MAC_AGING_EN defined: prescaler, sweep engine, age storage present as above.
- Undefined: no age storage, no prescaler; entries persist until reset or overwritten; o_sweep_active tied 0; o_entry_count only increments. pAGE_MAX, pTICK_DIV ignored.

## Test plan
- Reset, lookup slot 5 → o_lookup_valid next cycle, hit=0, port=0, count=0.
- Ports 0 and 2 request slots 3 and 9 together, pointer 0 → ack port 0 cycle N+1, port 2 cycle N+2; lookup 9 → hit=1, port=2; count=2.
- All 4 ports hold requests (re-asserted after ack) → ack order 0,1,2,3,0,1.
- pAGE_MAX=3, pTICK_DIV=256, pSLOTS=64: port 1 learns slot 7 → hit through 2 sweeps, miss after 3rd sweep passes slot 7; count 1→0.
- Slot 7 at age 1; port 0 learns slot 7 in the cycle sweep visits 7 → remains valid, age=3, count unchanged.
- Port 1 learns slot 4, then port 3 learns slot 4 → lookup 4 returns port 3, count stays 1.

Source files
------------

// File: rtl/mac_learn_table.sv
// MAC source-address learning table: round-robin learn arbiter, registered lookup port,
// and (with MAC_AGING_EN defined) a per-tick background aging sweep that expires stale entries.
module mac_learn_table #(
    parameter int pPORTS    = 4,
    parameter int pSLOTS    = 64,
    parameter int pAGE_MAX  = 300,
    parameter int pTICK_DIV = 32768,
    localparam int AW = $clog2(pSLOTS),
    localparam int PW = $clog2(pPORTS),
    localparam int CW = $clog2(pSLOTS + 1)
) (
    input  logic                 iclk,
    input  logic                 irst,
    input  logic [pPORTS-1:0]    i_learn_req,
    input  logic [pPORTS*AW-1:0] i_learn_slot,
    output logic [pPORTS-1:0]    o_learn_ack,
    input  logic                 i_lookup_en,
    input  logic [AW-1:0]        i_lookup_slot,
    output logic                 o_lookup_valid,
    output logic                 o_lookup_hit,
    output logic [PW-1:0]        o_lookup_port,
    output logic                 o_sweep_active,
    output logic [CW-1:0]        o_entry_count
);

    if (pPORTS < 2 || pAGE_MAX < 1 || pTICK_DIV < 2 * pSLOTS || (pSLOTS & (pSLOTS - 1)) != 0) begin : g_cfg_check
        $error("mac_learn_table: invalid parameter set");
    end

    logic [pSLOTS-1:0] valid_reg;
    logic [PW-1:0]     port_reg [pSLOTS];
    logic [PW-1:0]     ptr_reg;
    logic [PW-1:0]     ptr_next;
    logic [pPORTS-1:0] ack_reg;
    logic              lookup_valid_reg;
    logic              lookup_hit_reg;
    logic [PW-1:0]     lookup_port_reg;
    logic [CW-1:0]     count_reg;
    logic [CW-1:0]     count_next;

    logic [AW-1:0]     slot_arr [pPORTS];
    logic [PW:0]       scan_sum [pPORTS];
    logic [PW-1:0]     scan_idx [pPORTS];
    logic              grant_vld;
    logic [PW-1:0]     grant_port;
    logic [AW-1:0]     grant_slot;
    logic              grant_new;
    logic              expire;

    // scan_idx[gi] is the port examined at priority position gi, i.e. (ptr + gi) mod pPORTS
    for (genvar gi = 0; gi < pPORTS; gi++) begin : g_port
        assign slot_arr[gi] = i_learn_slot[gi*AW +: AW];
        assign scan_sum[gi] = {1'b0, ptr_reg} + (PW+1)'(gi);
        assign scan_idx[gi] = (scan_sum[gi] >= (PW+1)'(pPORTS)) ?
                              PW'(scan_sum[gi] - (PW+1)'(pPORTS)) : scan_sum[gi][PW-1:0];
    end

    always_comb begin
        grant_vld  = 1'b0;
        grant_port = '0;
        for (int i = 0; i < pPORTS; i++) begin
            if (!grant_vld && i_learn_req[scan_idx[i]]) begin
                grant_vld  = 1'b1;
                grant_port = scan_idx[i];
            end
        end
        grant_slot = slot_arr[grant_port];
        grant_new  = grant_vld && !valid_reg[grant_slot];
        ptr_next   = ptr_reg;
        if (grant_vld) begin
            ptr_next = (grant_port == PW'(pPORTS - 1)) ? '0 : grant_port + PW'(1);
        end
    end

`ifdef MAC_AGING_EN
    localparam int GW = $clog2(pAGE_MAX + 1);
    localparam int TW = $clog2(pTICK_DIV);

    logic [GW-1:0] age_reg [pSLOTS];
    logic [TW-1:0] presc_reg;
    logic          sweep_active_reg;
    logic [AW-1:0] sweep_idx_reg;
    logic          tick;
    logic          sweep_live;
    logic          decrement;

    // A learn to the slot under the sweep takes precedence over aging it
    assign tick       = (presc_reg == TW'(pTICK_DIV - 1));
    assign sweep_live = sweep_active_reg && valid_reg[sweep_idx_reg] &&
                        !(grant_vld && grant_slot == sweep_idx_reg);
    assign expire     = sweep_live && (age_reg[sweep_idx_reg] == GW'(1));
    assign decrement  = sweep_live && (age_reg[sweep_idx_reg] > GW'(1));

    always_ff @(posedge iclk) begin
        if (irst) begin
            presc_reg        <= '0;
            sweep_active_reg <= 1'b0;
            sweep_idx_reg    <= '0;
            for (int i = 0; i < pSLOTS; i++) begin
                age_reg[i] <= '0;
            end
        end else begin
            presc_reg <= tick ? '0 : presc_reg + TW'(1);
            if (tick) begin
                sweep_active_reg <= 1'b1;
                sweep_idx_reg    <= '0;
            end else if (sweep_active_reg) begin
                if (sweep_idx_reg == AW'(pSLOTS - 1)) begin
                    sweep_active_reg <= 1'b0;
                end
                sweep_idx_reg <= sweep_idx_reg + AW'(1);
            end
            if (grant_vld) begin
                age_reg[grant_slot] <= GW'(pAGE_MAX);
            end
            if (decrement) begin
                age_reg[sweep_idx_reg] <= age_reg[sweep_idx_reg] - GW'(1);
            end
            if (expire) begin
                age_reg[sweep_idx_reg] <= '0;
            end
        end
    end

    assign o_sweep_active = sweep_active_reg;
`else
    assign expire         = 1'b0;
    assign o_sweep_active = 1'b0;
`endif

    always_comb begin
        count_next = count_reg;
        if (grant_new && !expire) begin
            count_next = count_reg + CW'(1);
        end else if (!grant_new && expire) begin
            count_next = count_reg - CW'(1);
        end
    end

    // Lookup samples the table before this edge's learn/expiry writes land
    always_ff @(posedge iclk) begin
        if (irst) begin
            valid_reg        <= '0;
            ptr_reg          <= '0;
            ack_reg          <= '0;
            lookup_valid_reg <= 1'b0;
            lookup_hit_reg   <= 1'b0;
            lookup_port_reg  <= '0;
            count_reg        <= '0;
            for (int i = 0; i < pSLOTS; i++) begin
                port_reg[i] <= '0;
            end
        end else begin
            ack_reg          <= '0;
            ptr_reg          <= ptr_next;
            count_reg        <= count_next;
            lookup_valid_reg <= i_lookup_en;
            lookup_hit_reg   <= i_lookup_en && valid_reg[i_lookup_slot];
            lookup_port_reg  <= (i_lookup_en && valid_reg[i_lookup_slot]) ? port_reg[i_lookup_slot] : '0;
`ifdef MAC_AGING_EN
            if (expire) begin
                valid_reg[sweep_idx_reg] <= 1'b0;
            end
`endif
            if (grant_vld) begin
                ack_reg[grant_port]  <= 1'b1;
                valid_reg[grant_slot] <= 1'b1;
                port_reg[grant_slot]  <= grant_port;
            end
        end
    end

    assign o_learn_ack    = ack_reg;
    assign o_lookup_valid = lookup_valid_reg;
    assign o_lookup_hit   = lookup_hit_reg;
    assign o_lookup_port  = lookup_port_reg;
    assign o_entry_count  = count_reg;

endmodule
